// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizes and types for the register file / in-use scoreboard.
// Opcode constants are kept here so decode and the scoreboard agree on them.
package regfile_scoreboard_pkg;

    localparam int NREGS     = 16;
    localparam int REG_IDX_W = 4;
    localparam int DATA_W    = 16;
    localparam int CNT_W     = 2;

    localparam logic [REG_IDX_W-1:0] OPC_LOAD  = 4'b1110;
    localparam logic [REG_IDX_W-1:0] OPC_STORE = 4'b1111;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]    data_t;
    typedef logic [CNT_W-1:0]     cnt_t;

    localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode-stage register-read / reserve / writeback bundle.
// master = decode + execute side, slave = register file.
interface regfile_scoreboard_if;
    import regfile_scoreboard_pkg::*;

    reg_idx_t srcReg1;
    reg_idx_t srcReg2;
    data_t    srcRegVal1;
    data_t    srcRegVal2;
    logic     inuse1;
    logic     inuse2;
    reg_idx_t nextDestReg;
    logic     reserve_en;
    logic     reserve_full;
    logic     wb_en;
    reg_idx_t wb_reg;
    data_t    wb_val;
    logic     flush;
    logic     err_ovf;
    logic     err_unf;

    modport master (
        output srcReg1, srcReg2, nextDestReg, reserve_en, wb_en, wb_reg, wb_val, flush,
        input  srcRegVal1, srcRegVal2, inuse1, inuse2, reserve_full, err_ovf, err_unf
    );

    modport slave (
        input  srcReg1, srcReg2, nextDestReg, reserve_en, wb_en, wb_reg, wb_val, flush,
        output srcRegVal1, srcRegVal2, inuse1, inuse2, reserve_full, err_ovf, err_unf
    );

endinterface

// File: rtl/regfile_scoreboard_sb_counter.sv
// One pending-write counter: saturates at both ends, flush clears it.
// A same-cycle increment and decrement cancel out.
module regfile_scoreboard_sb_counter
    import regfile_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc_req,
    input  logic dec_req,
    input  logic flush,
    output cnt_t cnt
);

    cnt_t cnt_q;
    cnt_t cnt_d;
    logic inc;
    logic dec;

    always_comb begin
        inc   = inc_req && (cnt_q != CNT_MAX);
        dec   = dec_req && (cnt_q != '0);
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (inc && !dec) begin
            cnt_d = cnt_q + cnt_t'(1);
        end else if (dec && !inc) begin
            cnt_d = cnt_q - cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with write-bypassed read ports and a per-register
// pending-write scoreboard; sticky overflow/underflow error flags.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    regfile_scoreboard_if.slave  rf
);

    data_t regs_q [NREGS];
    data_t regs_d [NREGS];
    cnt_t  cnt    [NREGS];
    logic  err_ovf_q;
    logic  err_ovf_d;
    logic  err_unf_q;
    logic  err_unf_d;
    logic  wb_act;
    logic  hit1;
    logic  hit2;
    cnt_t  cnt1;
    cnt_t  cnt2;

    // Qualifying with rst keeps the bypass path quiet while reset is held.
    assign wb_act = rf.wb_en & rst;

    for (genvar g = 0; g < NREGS; g++) begin : g_cnt
        logic inc_req;
        logic dec_req;

        assign inc_req = rf.reserve_en && (rf.nextDestReg == reg_idx_t'(g));
        assign dec_req = wb_act && (rf.wb_reg == reg_idx_t'(g));

        regfile_scoreboard_sb_counter u_sb_counter (
            .clk     (clk),
            .rst     (rst),
            .inc_req (inc_req),
            .dec_req (dec_req),
            .flush   (rf.flush),
            .cnt     (cnt[g])
        );
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_act) begin
            regs_d[rf.wb_reg] = rf.wb_val;
        end
    end

    always_comb begin
        hit1 = wb_act && (rf.wb_reg == rf.srcReg1);
        hit2 = wb_act && (rf.wb_reg == rf.srcReg2);
        cnt1 = cnt[rf.srcReg1];
        cnt2 = cnt[rf.srcReg2];

        rf.srcRegVal1 = hit1 ? rf.wb_val : regs_q[rf.srcReg1];
        rf.srcRegVal2 = hit2 ? rf.wb_val : regs_q[rf.srcReg2];

        // inuse reports the count as it will be after this cycle's writeback.
        rf.inuse1 = (cnt1 - cnt_t'(hit1 && (cnt1 != '0))) != '0;
        rf.inuse2 = (cnt2 - cnt_t'(hit2 && (cnt2 != '0))) != '0;

        rf.reserve_full = (cnt[rf.nextDestReg] == CNT_MAX);
    end

    always_comb begin
        err_ovf_d = err_ovf_q;
        err_unf_d = err_unf_q;
        if (!rf.flush) begin
            if (rf.reserve_en && rf.reserve_full) begin
                err_ovf_d = 1'b1;
            end
            if (wb_act && (cnt[rf.wb_reg] == '0)) begin
                err_unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    assign rf.err_ovf = err_ovf_q;
    assign rf.err_unf = err_unf_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic compared
// every cycle against a behavioural model of registers and pending counts.
module tb_regfile_scoreboard;
    import regfile_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    regfile_scoreboard_if bus ();

    regfile_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .rf  (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model: plain values and integer pending counts.
    int mregs [16] = '{default: 0};
    int mcnt  [16] = '{default: 0};
    bit movf = 0;
    bit munf = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_val(int s);
        if (rst && bus.wb_en && int'(bus.wb_reg) == s) return int'(bus.wb_val);
        return mregs[s];
    endfunction

    function automatic bit exp_inuse(int s);
        int c;
        c = mcnt[s];
        if (rst && bus.wb_en && int'(bus.wb_reg) == s && c > 0) c--;
        return c != 0;
    endfunction

    always @(negedge rst) begin
        for (int i = 0; i < 16; i++) begin
            mregs[i] = 0;
            mcnt[i]  = 0;
        end
        movf = 0;
        munf = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            int nc [16];
            int nd;
            int wr;
            nc = mcnt;
            nd = int'(bus.nextDestReg);
            wr = int'(bus.wb_reg);
            if (bus.flush) begin
                for (int i = 0; i < 16; i++) nc[i] = 0;
            end else begin
                if (bus.reserve_en) begin
                    if (mcnt[nd] < 3) nc[nd] = nc[nd] + 1;
                    else movf = 1;
                end
                if (bus.wb_en) begin
                    if (mcnt[wr] > 0) nc[wr] = nc[wr] - 1;
                    else munf = 1;
                end
            end
            if (bus.wb_en) mregs[wr] = int'(bus.wb_val);
            mcnt = nc;
        end
    end

    always @(negedge clk) begin
        check("val1",    32'(bus.srcRegVal1),  32'(exp_val(int'(bus.srcReg1))));
        check("val2",    32'(bus.srcRegVal2),  32'(exp_val(int'(bus.srcReg2))));
        check("inuse1",  32'(bus.inuse1),      32'(exp_inuse(int'(bus.srcReg1))));
        check("inuse2",  32'(bus.inuse2),      32'(exp_inuse(int'(bus.srcReg2))));
        check("full",    32'(bus.reserve_full), 32'(rst && mcnt[int'(bus.nextDestReg)] == 3));
        check("err_ovf", 32'(bus.err_ovf),     32'(movf));
        check("err_unf", 32'(bus.err_unf),     32'(munf));
    end

    task automatic tick();
        @(posedge clk);
        #2;
        bus.reserve_en = 1'b0;
        bus.wb_en      = 1'b0;
        bus.flush      = 1'b0;
    endtask

    task automatic reserve(int r);
        bus.reserve_en  = 1'b1;
        bus.nextDestReg = reg_idx_t'(r);
        tick();
    endtask

    task automatic set_wb(int r, int v);
        bus.wb_en  = 1'b1;
        bus.wb_reg = reg_idx_t'(r);
        bus.wb_val = data_t'(v);
    endtask

    initial begin
        bus.srcReg1 = '0; bus.srcReg2 = '0; bus.nextDestReg = '0;
        bus.reserve_en = 1'b0; bus.wb_en = 1'b0; bus.wb_reg = '0;
        bus.wb_val = '0; bus.flush = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        check("rst_val1", 32'(bus.srcRegVal1), 32'h0);
        check("rst_full", 32'(bus.reserve_full), 32'h0);
        rst = 1'b1;
        tick();

        // Reserve / retire r3
        reserve(3);
        bus.srcReg1 = 4'd3;
        #1 check("r3_inuse", 32'(bus.inuse1), 32'h1);
        set_wb(3, 16'hBEEF);
        #1 check("r3_bypass", 32'(bus.srcRegVal1), 32'hBEEF);
        check("r3_inuse_wb", 32'(bus.inuse1), 32'h0);
        tick();
        #1 check("r3_stored", 32'(bus.srcRegVal1), 32'hBEEF);

        // Two outstanding writes on r5
        reserve(5);
        reserve(5);
        bus.srcReg1 = 4'd5;
        set_wb(5, 16'h0001);
        #1 check("r5_inuse_a", 32'(bus.inuse1), 32'h1);
        tick();
        set_wb(5, 16'h0002);
        #1 check("r5_inuse_b", 32'(bus.inuse1), 32'h0);
        check("r5_val", 32'(bus.srcRegVal1), 32'h0002);
        tick();

        // Reserve and writeback r7 together
        reserve(7);
        bus.reserve_en = 1'b1; bus.nextDestReg = 4'd7;
        set_wb(7, 16'h1234);
        tick();
        bus.srcReg1 = 4'd7; bus.srcReg2 = 4'd7;
        #1 check("r7_inuse", 32'(bus.inuse1), 32'h1);
        check("r7_val1", 32'(bus.srcRegVal1), 32'h1234);
        check("r7_val2", 32'(bus.srcRegVal2), 32'h1234);

        // Saturation on r9, underflow on r2
        reserve(9); reserve(9); reserve(9);
        bus.nextDestReg = 4'd9;
        #1 check("r9_full", 32'(bus.reserve_full), 32'h1);
        check("ovf_before", 32'(bus.err_ovf), 32'h0);
        reserve(9);
        bus.srcReg1 = 4'd9;
        #1 check("ovf_after", 32'(bus.err_ovf), 32'h1);
        check("r9_inuse", 32'(bus.inuse1), 32'h1);
        set_wb(2, 16'h00FF);
        tick();
        bus.srcReg1 = 4'd2;
        #1 check("unf_set", 32'(bus.err_unf), 32'h1);
        check("r2_val", 32'(bus.srcRegVal1), 32'h00FF);

        // Flush
        reserve(1); reserve(4); reserve(4);
        bus.flush = 1'b1;
        tick();
        bus.srcReg1 = 4'd4; bus.srcReg2 = 4'd1;
        #1 check("fl_inuse1", 32'(bus.inuse1), 32'h0);
        check("fl_inuse2", 32'(bus.inuse2), 32'h0);
        bus.srcReg1 = 4'd3; bus.srcReg2 = 4'd9;
        #1 check("fl_val3", 32'(bus.srcRegVal1), 32'hBEEF);
        check("fl_inuse9", 32'(bus.inuse2), 32'h0);
        check("fl_ovf", 32'(bus.err_ovf), 32'h1);
        check("fl_unf", 32'(bus.err_unf), 32'h1);

        // Random traffic
        repeat (3000) begin
            bus.srcReg1     = reg_idx_t'($urandom_range(0, 15));
            bus.srcReg2     = ($urandom_range(0, 3) == 0) ? bus.srcReg1 : reg_idx_t'($urandom_range(0, 15));
            bus.reserve_en  = ($urandom_range(0, 99) < 45);
            bus.nextDestReg = ($urandom_range(0, 1) == 0) ? reg_idx_t'($urandom_range(0, 3))
                                                          : reg_idx_t'($urandom_range(0, 15));
            bus.wb_en       = ($urandom_range(0, 99) < 40);
            bus.wb_reg      = ($urandom_range(0, 1) == 0) ? reg_idx_t'($urandom_range(0, 3))
                                                          : reg_idx_t'($urandom_range(0, 15));
            bus.wb_val      = data_t'($urandom);
            bus.flush       = ($urandom_range(0, 99) < 3);
            @(posedge clk);
            #2;
        end

        // Asynchronous reset mid-cycle with traffic still on the bus
        bus.wb_en = 1'b1; bus.wb_reg = 4'd6; bus.srcReg1 = 4'd6; bus.srcReg2 = 4'd3;
        bus.reserve_en = 1'b1; bus.nextDestReg = 4'd6;
        set_wb(6, 16'hA5A5);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1 check("mr_val1", 32'(bus.srcRegVal1), 32'h0);
        check("mr_val2", 32'(bus.srcRegVal2), 32'h0);
        check("mr_inuse1", 32'(bus.inuse1), 32'h0);
        check("mr_inuse2", 32'(bus.inuse2), 32'h0);
        check("mr_full", 32'(bus.reserve_full), 32'h0);
        check("mr_ovf", 32'(bus.err_ovf), 32'h0);
        check("mr_unf", 32'(bus.err_unf), 32'h0);
        repeat (2) @(posedge clk);
        #2;
        bus.reserve_en = 1'b0; bus.wb_en = 1'b0; bus.flush = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.srcReg1 = reg_idx_t'(i);
            #1 check("post_rst_val", 32'(bus.srcRegVal1), 32'h0);
            check("post_rst_inuse", 32'(bus.inuse1), 32'h0);
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
